gpio_seq_ctrl: RTL

Bus-master sequencer that plays a programmed table of output patterns onto the 8-bit GPIO register block. It sits between a control source (CPU-side registers or a test harness) and the GPIO slave port. It issues one-cycle-capable bus writes to the GPIO `output_en` and `output_val` registers, with a programmable per-step delay. Looping, stop and done signalling are supported; an optional input-readback check is available.

---
 rtl/gpio_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_seq_ctrl.sv
// rtl/gpio_seq_ctrl.sv - table-driven sequencer writing GPIO output_en/output_val over a simple bus master port
// Optional feature macro: GPIO_SEQ_READBACK_EN adds an input_val readback and compare after each entry.
// Ports: clk, rst (async, active-high); start/stop/loop/seq_len sequence control;
//        cfg_we/cfg_idx/cfg_data pattern table load; m_bstart/m_write/m_addr/m_wdata/m_rdata/m_bdone bus master;
//        busy/done/cur_idx status; sample/mismatch readback result (held 0 without the macro).
module gpio_seq_ctrl #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] GPIO_BASE = 32'h0000_0000,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [AW:0]   seq_len,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_idx,
    input  logic [31:0]   cfg_data,
    output logic          m_bstart,
    output logic          m_write,
    output logic [31:0]   m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    input  logic          m_bdone,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_idx,
    output logic [7:0]    sample,
    output logic          mismatch
);
    localparam logic [31:0] OFS_IN  = 32'h0000_0000;
    localparam logic [31:0] OFS_OE  = 32'h0000_0008;
    localparam logic [31:0] OFS_VAL = 32'h0000_000C;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WR_OE, S_WR_VAL, S_RD_IN, S_WAIT, S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic [15:0]   delay_q, delay_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    oe_q, oe_d;
    logic [7:0]    val_q, val_d;
    logic [7:0]    sample_q, sample_d;
    logic          mismatch_q, mismatch_d;
    logic          stop_pend_q, stop_pend_d;

    logic [31:0]   table_q [DEPTH];

    logic          stop_req;
    logic [AW:0]   idx_inc;
    state_t        adv_state;
    logic [AW-1:0] adv_idx;
    state_t        post_state;
    logic [AW-1:0] post_idx;

`ifdef GPIO_SEQ_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^m_rdata[31:8];
`else
    logic unused_rdata;
    assign unused_rdata = ^m_rdata;
`endif

    // Pattern table has no reset so contents survive a sequencer reset.
    // A same-edge fetch reads the pre-write contents.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            table_q[cfg_idx] <= cfg_data;
        end
    end

    // End-of-entry decision, shared by the bus states (zero delay) and WAIT.
    always_comb begin
        stop_req = stop | stop_pend_q;
        idx_inc  = {1'b0, idx_q} + (AW+1)'(1);
        if (stop_req) begin
            adv_state = S_FINISH;
            adv_idx   = idx_q;
        end else if (idx_inc < len_q) begin
            adv_state = S_FETCH;
            adv_idx   = idx_inc[AW-1:0];
        end else if (loop) begin
            adv_state = S_FETCH;
            adv_idx   = '0;
        end else begin
            adv_state = S_FINISH;
            adv_idx   = idx_q;
        end
        // A zero delay skips WAIT entirely so the entry period stays 3+delay.
        if (stop_req) begin
            post_state = S_FINISH;
            post_idx   = idx_q;
        end else if (delay_q == 16'd0) begin
            post_state = adv_state;
            post_idx   = adv_idx;
        end else begin
            post_state = S_WAIT;
            post_idx   = idx_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        delay_d    = delay_q;
        oe_d       = oe_q;
        val_d      = val_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        mismatch_d = mismatch_q;
        // A stop pulse arriving during a stalled transfer is remembered until the transfer ends.
        stop_pend_d = (state_q == S_IDLE) ? 1'b0 : (stop_pend_q | stop);
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    len_d      = seq_len;
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                    state_d    = (seq_len != '0) ? S_FETCH : S_FINISH;
                end
            end
            S_FETCH: begin
                if (stop_req) begin
                    state_d = S_FINISH;
                end else begin
                    {delay_d, oe_d, val_d} = table_q[idx_q];
                    state_d = S_WR_OE;
                end
            end
            S_WR_OE: begin
                if (m_bdone) begin
                    state_d = stop_req ? S_FINISH : S_WR_VAL;
                end
            end
            S_WR_VAL: begin
                if (m_bdone) begin
`ifdef GPIO_SEQ_READBACK_EN
                    state_d = stop_req ? S_FINISH : S_RD_IN;
`else
                    state_d = post_state;
                    idx_d   = post_idx;
                    cnt_d   = delay_q - 16'd1;
`endif
                end
            end
`ifdef GPIO_SEQ_READBACK_EN
            S_RD_IN: begin
                if (m_bdone) begin
                    sample_d = m_rdata[7:0];
                    // Only pins driven by this entry are compared.
                    if (((m_rdata[7:0] ^ val_q) & oe_q) != 8'h00) begin
                        mismatch_d = 1'b1;
                    end
                    state_d = post_state;
                    idx_d   = post_idx;
                    cnt_d   = delay_q - 16'd1;
                end
            end
`endif
            S_WAIT: begin
                if (stop_req) begin
                    state_d = S_FINISH;
                end else if (cnt_q == 16'd0) begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus outputs decode from state so an async reset drops m_bstart at once.
    always_comb begin
        m_bstart = 1'b0;
        m_write  = 1'b0;
        m_addr   = 32'h0;
        m_wdata  = 32'h0;
        case (state_q)
            S_WR_OE: begin
                m_bstart = 1'b1;
                m_write  = 1'b1;
                m_addr   = GPIO_BASE + OFS_OE;
                m_wdata  = {24'h0, oe_q};
            end
            S_WR_VAL: begin
                m_bstart = 1'b1;
                m_write  = 1'b1;
                m_addr   = GPIO_BASE + OFS_VAL;
                m_wdata  = {24'h0, val_q};
            end
`ifdef GPIO_SEQ_READBACK_EN
            S_RD_IN: begin
                m_bstart = 1'b1;
                m_addr   = GPIO_BASE + OFS_IN;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            delay_q     <= 16'h0;
            cnt_q       <= 16'h0;
            oe_q        <= 8'h0;
            val_q       <= 8'h0;
            sample_q    <= 8'h0;
            mismatch_q  <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            delay_q     <= delay_d;
            cnt_q       <= cnt_d;
            oe_q        <= oe_d;
            val_q       <= val_d;
            sample_q    <= sample_d;
            mismatch_q  <= mismatch_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FINISH);
    assign cur_idx  = idx_q;
    assign sample   = sample_q;
    assign mismatch = mismatch_q;
endmodule
